// File: rtl/ms_timeout_timer.sv
// rtl/ms_timeout_timer.sv - millisecond timeout timer driven by the sideband ms divider
//
// Purpose: detects rising edges of the divided ms_clk in the sb_clk domain and
// counts whole milliseconds after a start request. When the elapsed count
// reaches the sampled timeout it raises a one-cycle timeout pulse and a sticky
// expired flag.
//
// Build option: MS_TIMER_AUTO_RELOAD_EN selects periodic mode. On expiry the
// count returns to 0 and the timer keeps running. A timeout of 0 is still
// one-shot. Without the macro the timer is one-shot.
//
// Ports:
//   sb_clk      sideband clock, all logic on the rising edge
//   rst         asynchronous active-high reset
//   ms_clk      divided ms clock, a register output in the sb_clk domain
//   start       pulse: sample timeout_val, clear elapsed, arm
//   stop        pulse: abort, clear expired, go idle
//   timeout_val timeout in ms, sampled only with start
//   busy        high while counting
//   timeout     one-cycle pulse on expiry
//   expired     sticky expiry flag
//   elapsed     ms ticks counted since the last start
module ms_timeout_timer #(
  parameter int CNT_W = 8
) (
  input  logic             sb_clk,
  input  logic             rst,
  input  logic             ms_clk,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] timeout_val,
  output logic             busy,
  output logic             timeout,
  output logic             expired,
  output logic [CNT_W-1:0] elapsed
);

`ifdef MS_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ms_clk_d;
  logic             tick;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] target_nxt;
  logic [CNT_W-1:0] elapsed_nxt;
  logic [CNT_W-1:0] elapsed_inc;
  logic             timeout_nxt;
  logic             expired_nxt;

  // ms_clk already comes from a register in this domain, so one delay stage
  // is enough for edge detection.
  assign tick        = ms_clk & ~ms_clk_d;
  assign elapsed_inc = elapsed + 1'b1;
  assign busy        = (state == RUN);

  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ms_clk_d <= 1'b0;
      target   <= '0;
      elapsed  <= '0;
      timeout  <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ms_clk_d <= ms_clk;
      target   <= target_nxt;
      elapsed  <= elapsed_nxt;
      timeout  <= timeout_nxt;
      expired  <= expired_nxt;
    end
  end

  // stop beats start, and start beats tick. A tick that coincides with a
  // restart is dropped because start clears the count.
  always_comb begin
    state_nxt   = state;
    target_nxt  = target;
    elapsed_nxt = elapsed;
    timeout_nxt = 1'b0;
    expired_nxt = expired;

    if (stop) begin
      state_nxt   = IDLE;
      expired_nxt = 1'b0;
    end else if (start) begin
      state_nxt   = RUN;
      target_nxt  = timeout_val;
      elapsed_nxt = '0;
      expired_nxt = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (target == '0) begin
            // A zero timeout expires on the first cycle of RUN without
            // waiting for a tick. It is one-shot even in periodic mode.
            timeout_nxt = 1'b1;
            expired_nxt = 1'b1;
            state_nxt   = DONE;
          end else if (tick) begin
            elapsed_nxt = elapsed_inc;
            if (elapsed_inc == target) begin
              timeout_nxt = 1'b1;
              expired_nxt = 1'b1;
              if (AUTO_RELOAD) begin
                elapsed_nxt = '0;
              end else begin
                state_nxt = DONE;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ms_timeout_timer.sv
// tb/tb_ms_timeout_timer.sv - self-checking bench for ms_timeout_timer
module tb_ms_timeout_timer;

`ifdef MS_TIMER_AUTO_RELOAD_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ms_clk;
  logic       start;
  logic       stop;
  logic [7:0] timeout_val;
  logic       busy;
  logic       timeout;
  logic       expired;
  logic [7:0] elapsed;

  int total = 0;
  int bad   = 0;
  int pulses;
  int dcnt;
  int per;

  // Reference model. It tracks only what the timer can be seen to do: whether
  // it is counting, the sticky flag, the count and the target.
  bit m_armed, m_exp, m_tout, m_prev;
  int m_cnt, m_tgt;

  ms_timeout_timer #(.CNT_W(8)) dut (
    .sb_clk(clk),
    .rst(rst),
    .ms_clk(ms_clk),
    .start(start),
    .stop(stop),
    .timeout_val(timeout_val),
    .busy(busy),
    .timeout(timeout),
    .expired(expired),
    .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_exp = 0; m_tout = 0; m_prev = 0; m_cnt = 0; m_tgt = 0;
  endtask

  task automatic model_step();
    bit tk;
    tk = ms_clk && !m_prev;
    m_prev = ms_clk;
    m_tout = 0;
    if (stop) begin
      m_armed = 0; m_exp = 0;
    end else if (start) begin
      m_armed = 1; m_exp = 0; m_tgt = timeout_val; m_cnt = 0;
    end else if (m_armed) begin
      if (m_tgt == 0) begin
        m_tout = 1; m_exp = 1; m_armed = 0;
      end else if (tk) begin
        m_cnt++;
        if (m_cnt == m_tgt) begin
          m_tout = 1; m_exp = 1;
          if (AUTO != 0) m_cnt = 0;
          else m_armed = 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string ph);
    chk({ph, "_busy"}, busy, m_armed);
    chk({ph, "_timeout"}, timeout, m_tout);
    chk({ph, "_expired"}, expired, m_exp);
    chk({ph, "_elapsed"}, elapsed, m_cnt);
  endtask

  // One sb_clk cycle. The bench drives inputs at the negedge, lets the DUT and
  // the model step on the posedge, and checks at the next negedge.
  task automatic cyc(input bit s, input bit p, input int v);
    start = s;
    stop = p;
    timeout_val = v[7:0];
    dcnt = (dcnt + 1) % per;
    ms_clk = (dcnt >= per / 2);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all("cyc");
    pulses += int'(timeout);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic run_until_cnt(input int n, input int limit);
    int k = 0;
    while (m_cnt != n && k < limit) begin
      cyc(0, 0, 0);
      k++;
    end
  endtask

  // Idle until the next cycle would raise ms_clk.
  task automatic wait_rise();
    while (((dcnt + 1) % per) != per / 2) cyc(0, 0, 0);
  endtask

  task automatic async_reset(input string ph);
    #2;
    rst = 1'b1;
    ms_clk = 1'b0;
    dcnt = 0;
    model_reset();
    #1;
    compare_all(ph);
    @(negedge clk);
    compare_all(ph);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; timeout_val = 0; ms_clk = 0;
    dcnt = 0; per = 1000; pulses = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Basic count to 3.
    pulses = 0;
    cyc(1, 0, 3);
    chk("t1_busy_after_start", busy, 1);
    chk("t1_elapsed_after_start", elapsed, 0);
    run(4000);
    chk("t1_pulses", pulses, 1);
    chk("t1_expired", expired, 1);
    cyc(0, 1, 0);

    // Stop after two ticks.
    cyc(1, 0, 5);
    run_until_cnt(2, 3000);
    cyc(0, 1, 0);
    pulses = 0;
    run(10000);
    chk("t2_pulses", pulses, 0);
    chk("t2_elapsed", elapsed, 2);
    chk("t2_expired", expired, 0);
    chk("t2_busy", busy, 0);

    // Restart mid-count with a shorter timeout.
    cyc(1, 0, 4);
    run_until_cnt(3, 4000);
    chk("t3_elapsed_before", elapsed, 3);
    cyc(1, 0, 2);
    chk("t3_elapsed_reload", elapsed, 0);
    pulses = 0;
    run(2500);
    chk("t3_pulses", pulses, 1);
    cyc(0, 1, 0);

    // Zero timeout expires on the cycle after start.
    cyc(1, 0, 0);
    chk("t4_busy", busy, 1);
    chk("t4_timeout_early", timeout, 0);
    cyc(0, 0, 0);
    chk("t4_timeout", timeout, 1);
    chk("t4_done_busy", busy, 0);
    chk("t4_done_expired", expired, 1);

    // start and stop together while in DONE.
    cyc(1, 1, 5);
    chk("t5_busy", busy, 0);
    chk("t5_expired", expired, 0);

    // start coincident with a tick drops the tick.
    cyc(1, 0, 9);
    wait_rise();
    cyc(1, 0, 9);
    chk("t5_tick_drop", elapsed, 0);
    run(1200);
    chk("t5_next_tick", elapsed, 1);
    cyc(0, 1, 0);

    // Periodic behaviour over 8 ms.
    cyc(1, 0, 2);
    pulses = 0;
    run(8000);
    chk("t6_pulses", pulses, (AUTO != 0) ? 4 : 1);
    chk("t6_busy", busy, (AUTO != 0) ? 1 : 0);
    cyc(0, 1, 0);
    chk("t6_stop_busy", busy, 0);

    // Asynchronous reset mid-count.
    cyc(1, 0, 5);
    run(1500);
    async_reset("t7_rst");
    pulses = 0;
    run(3000);
    chk("t7_no_timeout", pulses, 0);

    // Randomized traffic with short ms periods.
    for (int seg = 0; seg < 40; seg++) begin
      per = $urandom_range(4, 24);
      dcnt = dcnt % per;
      for (int i = 0; i < 500; i++) begin
        int r;
        r = $urandom_range(0, 199);
        if (r == 77) begin
          @(negedge clk);
          async_reset("rnd_rst");
        end else begin
          cyc(r < 6, (r >= 6 && r < 9) || r == 199, $urandom_range(0, 6));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ms_timeout_timer.md
# ms_timeout_timer

Millisecond timeout timer for the sideband logical layer, sitting directly downstream of the sideband millisecond clock divider. It edge-detects the divided `ms_clk` (period 1000 `sb_clk` cycles) in the `sb_clk` domain, counts whole milliseconds after a `start` request, and flags expiry of a programmable timeout. Link-training and sideband-transaction FSMs use it for their ms-scale timeouts.

## Interface
- `CNT_W`, default 8: width of timeout value and elapsed counter (max timeout 2^CNT_W-1 ms).
- `sb_clk`  in  1  sideband clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ms_clk`  in  1  divided clock from the ms divider, a register output in the `sb_clk` domain; no synchronizer.
- `start`  in  1  single-cycle pulse; loads `timeout_val`, clears elapsed count, arms the timer.
- `stop`  in  1  single-cycle pulse; aborts and returns to idle.
- `timeout_val`  in  CNT_W  timeout in ms, sampled only in the `start` cycle.
- `busy`  out  1  high while state is RUN.
- `timeout`  out  1  one-cycle pulse on expiry.
- `expired`  out  1  sticky expiry flag; cleared by `start`, `stop` or reset.
- `elapsed`  out  CNT_W  ms ticks counted since the last `start`.

## Operation
- Tick detect: `ms_clk_d` registers `ms_clk`; `tick = ms_clk & ~ms_clk_d`. One tick per ms_clk rising edge.
- Internal `target` register (CNT_W) holds the sampled `timeout_val`.
- States: IDLE, RUN, DONE.
- IDLE: `busy`=0; ticks ignored; `elapsed` holds its last value. `start` -> RUN.
- RUN: on `tick`, `elapsed` increments. When `tick` and `elapsed+1 == target`: `timeout` pulses, `expired` sets, and the state moves to DONE.
- DONE: `busy`=0; `elapsed` frozen at `target`; `expired`=1. `start` -> RUN. `stop` -> IDLE.
- Priority in any state: `stop` > `start` > `tick`. With `stop` and `start` in the same cycle, the result is IDLE with `expired`=0.
- `start` in RUN restarts: `elapsed`=0 and `target` reloads; a tick in the same cycle is dropped.
- `timeout_val`=0: RUN is entered, and on the next cycle `timeout` pulses and the state moves to DONE without waiting for a tick.
- Granularity: the first tick arrives 1 to 1000 `sb_clk` cycles after `start`. Real delay is in (N-1, N] ms; callers needing at least N ms program N+1.
- `elapsed` never wraps in one-shot mode. It cannot exceed `target`.

## Timing
- Reset values: `busy`=0, `timeout`=0, `expired`=0, `elapsed`=0, state IDLE, `target`=0, `ms_clk_d`=0. The divider holds `ms_clk`=0 while in reset, so no spurious tick occurs on release.
- Let E be the `sb_clk` edge where `ms_clk` rises. `tick` is high in the cycle after E. `elapsed` updates at edge E+1.
- `timeout` and `expired` assert at the same edge as the final `elapsed` update. `timeout` is high for exactly one cycle.
- `start` at edge S: `busy`=1 and `elapsed`=0 after S.
- `stop` at edge S: `busy`=0 and `expired`=0 after S. No `timeout` pulse follows.
- Asynchronous `rst` mid-count clears everything immediately; no `timeout` is emitted.

## Configuration
- `MS_TIMER_AUTO_RELOAD_EN` defined (periodic mode):
  - On expiry, `timeout` pulses, `expired` sets, `elapsed` returns to 0, and the state stays RUN.
  - A `timeout` pulse is produced every `target` ms until `stop`.
  - With `timeout_val`=0, the timer behaves as one-shot (enters DONE).
- Macro undefined: one-shot behaviour exactly as described under Operation.

## Test plan
- Reset, then `start` with `timeout_val`=3 and the divider running: `elapsed` steps 1, 2, 3 one edge after each ms_clk rise. The `timeout` pulse is 1 cycle wide, coincident with `elapsed`=3. Afterwards `busy`=0 and `expired`=1.
- `start` with `timeout_val`=5, `stop` after 2 ticks: `busy`=0, `expired`=0, `elapsed`=2, and no `timeout` pulse within 10 ms.
- `start` with `timeout_val`=4, re-`start` with `timeout_val`=2 after 3 ticks: `elapsed` reloads to 0, and `timeout` fires after 2 more ticks, not at 4.
- `start` with `timeout_val`=0: `timeout` pulses on the cycle after `start`, and the state is DONE.
- Simultaneous `start` and `stop` while in DONE: result is IDLE with `expired`=0. Separately, `start` coincident with `tick`: `elapsed`=0 and the tick is not counted.
- With `MS_TIMER_AUTO_RELOAD_EN` and `timeout_val`=2: `timeout` pulses every 2000 `sb_clk` cycles, four times in 8 ms, with `busy`=1 throughout. Then `stop` gives `busy`=0. Also assert `rst` mid-count: all outputs go to 0 asynchronously.
